inv_mix_columns_seq: RTL and testbench

- Implements the AES InvMixColumns transform (FIPS 197 §5.3.3) for the decryption datapath. It is the inverse of the encrypt-side MixColumns stage.
- Column-serial: one 32-bit column is transformed per clock using a single shared GF(2^8) multiplier column, which trades latency for area.
- Has valid/ready handshakes on both sides, so it can sit between InvShiftRows/InvSubBytes and AddRoundKey stages that may stall.

---
 rtl/inv_mix_columns_seq.sv | 153 +++++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns, column-serial: one 32-bit column per clock through a
// single shared GF(2^8) multiplier column, valid/ready on both sides.
// Optional feature macro: INV_MIX_BYPASS_EN adds a 'bypass' input that keeps
// the same latency/handshake but leaves the state unmodified (final round).
module inv_mix_columns_seq #(
  parameter int DATA_W = 128,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
`ifdef INV_MIX_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] LAST_COL = 2'(COLS - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   work_q, work_d;
`ifdef INV_MIX_BYPASS_EN
  logic                bypass_q, bypass_d;
`endif

  logic                accept;
  logic                skip_mix;
  logic [1:0]          col_sel;
  logic [31:0]         col_cur;
  logic [31:0]         col_mixed;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMix of one column (s0 is the most significant byte).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r0, r1, r2, r3;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[(3-i)*8 +: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    r0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    r1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    r2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    r3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {r0, r1, r2, r3};
  endfunction

  // Column c sits at bits [(3-c)*32 +: 32]; the shared multiplier sees only it.
  assign col_sel   = 2'd3 - cnt_q;
  assign col_cur   = work_q[{col_sel, 5'b0} +: 32];
  assign col_mixed = inv_mix_col(col_cur);
  assign accept    = valid_in & ready_out;
  assign data_out  = work_q;

`ifdef INV_MIX_BYPASS_EN
  assign skip_mix = bypass_q;
`else
  assign skip_mix = 1'b0;
`endif

  // Next-state, handshake outputs and in-place column update.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
`ifdef INV_MIX_BYPASS_EN
    bypass_d  = bypass_q;
`endif

    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
      end
      BUSY: begin
        if (!skip_mix) begin
          work_d[{col_sel, 5'b0} +: 32] = col_mixed;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_out = 1'b1;
        ready_out = ready_in;
        if (ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new state may be taken in IDLE or, back-to-back, on the DONE handshake.
    if (accept) begin
      work_d  = data_in;
      cnt_d   = 2'd0;
      state_d = BUSY;
`ifdef INV_MIX_BYPASS_EN
      bypass_d = bypass;
`endif
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      work_q   <= '0;
`ifdef INV_MIX_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
`ifdef INV_MIX_BYPASS_EN
      bypass_q <= bypass_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed vectors plus random
// states compared against a matrix-form GF(2^8) reference model.
module tb_inv_mix_columns_seq;

  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_in;
  logic              bypass;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.DATA_W(DATA_W), .COLS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_in   (data_in),
`ifdef INV_MIX_BYPASS_EN
    .bypass    (bypass),
`endif
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .data_out  (data_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: generic shift-and-add GF(2^8) product.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Reference: full-state matrix product with the circulant inverse matrix.
  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [7:0]   st   [16];
    logic [7:0]   acc;
    logic [127:0] r;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    for (int i = 0; i < 16; i++) st[i] = s[(15-i)*8 +: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(base[(k - row + 4) % 4], st[4*c + k]);
        r[(15 - (4*c + row))*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One transaction: accept, wait for result, optional stall, handshake.
  task automatic send_and_expect(input logic [127:0] d, input logic [127:0] exp,
                                 input int stall, input bit garbage, input bit byp);
    int lat;
    bit busy_ok;
    bit stall_ok;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    bypass   = byp;
    ready_in = 1'b0;
    #1;
    check("accept_ready", 128'(ready_out), 128'(1));
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_out && lat < 20) begin
      if (ready_out) busy_ok = 1'b0;
      if (garbage) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = rand128();
      end
      @(negedge clk);
      lat++;
    end
    valid_in = 1'b0;
    check("busy_ready_low", 128'(busy_ok), 128'(1));
    check("latency", 128'(lat), 128'(4));
    stall_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (valid_out !== 1'b1 || data_out !== exp || ready_out !== 1'b0) stall_ok = 1'b0;
      @(negedge clk);
    end
    if (stall > 0) check("stall_stable", 128'(stall_ok), 128'(1));
    ready_in = 1'b1;
    #1;
    check("result", data_out, exp);
    check("done_ready", 128'(ready_out), 128'(1));
    @(posedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    check("single_handshake", 128'(valid_out), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [127:0] d;
    int stall;
    bit garb;
    bit byp;

    reset    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    bypass   = 1'b0;
    data_in  = '0;
    #12;
    check("reset_valid", 128'(valid_out), 128'(0));
    check("reset_data", data_out, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset_ready", 128'(ready_out), 128'(1));

    // Known FIPS-197 vector, no stall then 10-cycle stall.
    send_and_expect(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8,
                    128'hdb135345_f20a225c_01010101_2d26314c, 0, 1'b0, 1'b0);
    send_and_expect(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8,
                    128'hdb135345_f20a225c_01010101_2d26314c, 10, 1'b0, 1'b0);

    // Back-to-back with valid_in held high.
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = {4{32'hc6c6c6c6}};
    ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = {4{32'hd5d5d7d6}};
    lat = 0;
    while (!valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat1", 128'(lat), 128'(4));
    check("b2b_data1", data_out, {4{32'hc6c6c6c6}});
    check("b2b_ready", 128'(ready_out), 128'(1));
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    check("b2b_busy", 128'(valid_out), 128'(0));
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_gap", 128'(lat), 128'(5));
    check("b2b_data2", data_out, {4{32'hd4d4d4d5}});
    @(posedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    check("b2b_done", 128'(valid_out), 128'(0));

    // Reset two cycles into BUSY.
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = rand128();
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_valid", 128'(valid_out), 128'(0));
    check("abort_data", data_out, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    send_and_expect({4{32'h01010101}}, {4{32'h01010101}}, 0, 1'b0, 1'b0);

    // Garbage on the input side while BUSY.
    d = rand128();
    send_and_expect(d, ref_inv_mix(d), 2, 1'b1, 1'b0);

`ifdef INV_MIX_BYPASS_EN
    send_and_expect(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8,
                    128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 0, 1'b0, 1'b1);
`endif

    // Randomized states, stalls and input noise.
    for (int n = 0; n < 16; n++) begin
      d     = rand128();
      stall = int'($urandom_range(0, 3));
      garb  = 1'($urandom_range(0, 1));
`ifdef INV_MIX_BYPASS_EN
      byp   = 1'($urandom_range(0, 1));
`else
      byp   = 1'b0;
`endif
      send_and_expect(d, byp ? d : ref_inv_mix(d), stall, garb, byp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
